// File: rtl/data_memory_banked.sv
// data_memory_banked: four byte-lane banks with valid/ready access, registered response and clear engine.
// Build macro DMEM_MISALIGN_EN enables single-access misaligned H/HU/W transfers.
module data_memory_banked #(
    parameter int DEPTH_WORDS    = 256,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Clear,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        DMWr,
    input  logic [2:0]  DMCtrl,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] DataRd,
    output logic        RspErr,
    output logic        Busy
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   data_rd_q, data_rd_d;
    logic          busy, accept, err, bad_op, oor;
    logic [1:0]    lane;
    logic [AW-1:0] word;
    logic [2:0]    size;
    logic [31:0]   rot, ext;
    logic [7:0]    rd_byte [4];

    // Decode the request: lane/word split, access size, error conditions and load-data assembly.
    always_comb begin
        lane   = Address[1:0];
        word   = Address[AW+1:2];
        size   = (DMCtrl[1:0] == 2'b00) ? 3'd1 : (DMCtrl[1:0] == 2'b01) ? 3'd2 : 3'd4;
        bad_op = (DMCtrl == 3'b011) | (DMCtrl[2:1] == 2'b11) | (DMWr & DMCtrl[2]);
        oor    = |Address[31:AW+2];
`ifdef DMEM_MISALIGN_EN
        err    = oor | bad_op | (({1'b0, lane} + size > 3'd4) & (&word));
`else
        err    = oor | bad_op | ((DMCtrl[1:0] == 2'b01) & lane[0]) | ((DMCtrl[1:0] == 2'b10) & (lane != 2'b00));
`endif
        for (int i = 0; i < 4; i++)
            rot[8*i +: 8] = rd_byte[lane + 2'(i)];
        ext = (DMCtrl[1:0] == 2'b00) ? {{24{~DMCtrl[2] & rot[7]}}, rot[7:0]} :
              (DMCtrl[1:0] == 2'b01) ? {{16{~DMCtrl[2] & rot[15]}}, rot[15:0]} : rot;
    end

    // Bank k holds byte lane k; access byte j lands in bank (lane + j) mod 4, spilling into word+1 below lane.
    for (genvar k = 0; k < 4; k++) begin : g_bank
        logic [7:0]    mem [DEPTH_WORDS];
        logic [1:0]    j;
        logic [AW-1:0] ba, wa;
        logic          we;
        logic [7:0]    wd;
        // Per-bank address, write enable and write byte; the clear engine overrides requests.
        always_comb begin
            j  = 2'(k) - lane;
            ba = (2'(k) >= lane) ? word : word + AW'(1);
            we = busy | (accept & DMWr & ~err & ({1'b0, j} < size));
            wa = busy ? clr_idx_q : ba;
            wd = busy ? 8'h00 : DataWr[8*j +: 8];
        end
        // Bank storage; contents deliberately have no reset.
        always_ff @(posedge clk) if (we) mem[wa] <= wd;
        assign rd_byte[k] = mem[ba];
    end

    // Clear engine sequencing, request acceptance and response register next-state.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy      = (state_q == CLEAR);
        ReqReady  = ~busy & ~Clear & (~rsp_valid_q | RspReady);
        accept    = ReqValid & ReqReady;
        if (busy) begin
            clr_idx_d = clr_idx_q + AW'(1);
            if (&clr_idx_q) state_d = IDLE;
        end else if (Clear) begin
            state_d   = CLEAR;
            clr_idx_d = '0;
        end
        rsp_valid_d = accept | (rsp_valid_q & ~RspReady);
        rsp_err_d   = accept ? err : rsp_err_q;
        data_rd_d   = accept ? ((DMWr | err) ? 32'h0 : ext) : data_rd_q;
    end

    // State, clear counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            data_rd_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            data_rd_q   <= data_rd_d;
        end
    end

    assign RspValid = rsp_valid_q;
    assign RspErr   = rsp_err_q;
    assign DataRd   = data_rd_q;
    assign Busy     = busy;
endmodule

// File: tb/tb_data_memory_banked.sv
// tb_data_memory_banked: directed-vector bench for data_memory_banked (DEPTH_WORDS=256, CLEAR_ON_RESET=1).
module tb_data_memory_banked;
    logic        clk = 1'b0, rst_n = 1'b0, Clear = 1'b0, ReqValid = 1'b0, DMWr = 1'b0, RspReady = 1'b1;
    logic        ReqReady, RspValid, RspErr, Busy;
    logic [2:0]  DMCtrl = 3'b010;
    logic [31:0] Address = 32'h0, DataWr = 32'h0, DataRd;
    int          tests = 0, fails = 0;
    logic        rv, re;
    logic [31:0] rd;

    data_memory_banked #(.DEPTH_WORDS(256), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst_n(rst_n), .Clear(Clear), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .DMWr(DMWr), .DMCtrl(DMCtrl), .Address(Address), .DataWr(DataWr), .RspValid(RspValid),
        .RspReady(RspReady), .DataRd(DataRd), .RspErr(RspErr), .Busy(Busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issue one request from a negedge; return the response seen one cycle after acceptance.
    task automatic xfer(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] wd,
                        output logic v, output logic e, output logic [31:0] d);
        int n = 0;
        DMWr = wr; DMCtrl = ctrl; Address = addr; DataWr = wd; ReqValid = 1'b1; RspReady = 1'b1;
        #1;
        while (ReqReady !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        ReqValid = 1'b0;
        v = (n < 50) ? RspValid : 1'b0;
        e = RspErr;
        d = DataRd;
    endtask

    task automatic test_reset();
        int   n = 0;
        logic rr_bad = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if ({RspValid, RspErr, DataRd, Busy, ReqReady} !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b0}) begin
            fails++; $display("FAIL reset_outputs: got %h expected %h", {RspValid, RspErr, DataRd, Busy, ReqReady}, {1'b0, 1'b0, 32'h0, 1'b1, 1'b0});
        end
        rst_n = 1'b1; #1;
        while (Busy === 1'b1 && n < 400) begin
            if (ReqReady !== 1'b0) rr_bad = 1'b1;
            n++;
            @(negedge clk); #1;
        end
        tests++; if (n != 256) begin fails++; $display("FAIL reset_clear_cycles: got %0d expected 256", n); end
        tests++; if (rr_bad !== 1'b0) begin fails++; $display("FAIL reset_clear_reqready: got 1 expected 0"); end
        @(negedge clk);
    endtask

    task automatic test_clear_result();
        xfer(1'b0, 3'b010, 32'h3FC, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'h0}) begin fails++; $display("FAIL lw_3fc_cleared: got %h expected %h", {rv, re, rd}, {2'b10, 32'h0}); end
        xfer(1'b0, 3'b010, 32'h010, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'h0}) begin fails++; $display("FAIL lw_010_cleared: got %h expected %h", {rv, re, rd}, {2'b10, 32'h0}); end
    endtask

    task automatic test_store_load();
        xfer(1'b1, 3'b010, 32'h10, 32'h8899AABB, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'h0}) begin fails++; $display("FAIL sw_010_rsp: got %h expected %h", {rv, re, rd}, {2'b10, 32'h0}); end
        xfer(1'b0, 3'b000, 32'h13, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'hFFFFFF88}) begin fails++; $display("FAIL lb_013: got %h expected %h", {rv, re, rd}, {2'b10, 32'hFFFFFF88}); end
        xfer(1'b0, 3'b100, 32'h13, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'h00000088}) begin fails++; $display("FAIL lbu_013: got %h expected %h", {rv, re, rd}, {2'b10, 32'h00000088}); end
        xfer(1'b0, 3'b001, 32'h12, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'hFFFF8899}) begin fails++; $display("FAIL lh_012: got %h expected %h", {rv, re, rd}, {2'b10, 32'hFFFF8899}); end
        xfer(1'b0, 3'b101, 32'h10, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'h0000AABB}) begin fails++; $display("FAIL lhu_010: got %h expected %h", {rv, re, rd}, {2'b10, 32'h0000AABB}); end
        xfer(1'b0, 3'b000, 32'h10, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'hFFFFFFBB}) begin fails++; $display("FAIL lb_010: got %h expected %h", {rv, re, rd}, {2'b10, 32'hFFFFFFBB}); end
    endtask

    task automatic test_partial();
        xfer(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, rv, re, rd);
        xfer(1'b1, 3'b001, 32'h22, 32'h00001234, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'h0}) begin fails++; $display("FAIL sh_022_rsp: got %h expected %h", {rv, re, rd}, {2'b10, 32'h0}); end
        xfer(1'b0, 3'b010, 32'h20, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'h1234BEEF}) begin fails++; $display("FAIL lw_020_after_sh: got %h expected %h", {rv, re, rd}, {2'b10, 32'h1234BEEF}); end
        xfer(1'b1, 3'b000, 32'h21, 32'hFFFFFF55, rv, re, rd);
        xfer(1'b0, 3'b010, 32'h20, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'h123455EF}) begin fails++; $display("FAIL lw_020_after_sb: got %h expected %h", {rv, re, rd}, {2'b10, 32'h123455EF}); end
    endtask

    task automatic test_errors();
        xfer(1'b1, 3'b010, 32'h400, 32'h11111111, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b11, 32'h0}) begin fails++; $display("FAIL sw_400_err: got %h expected %h", {rv, re, rd}, {2'b11, 32'h0}); end
        xfer(1'b0, 3'b010, 32'h400, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b11, 32'h0}) begin fails++; $display("FAIL lw_400_err: got %h expected %h", {rv, re, rd}, {2'b11, 32'h0}); end
        xfer(1'b0, 3'b010, 32'h80000010, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b11, 32'h0}) begin fails++; $display("FAIL lw_high_err: got %h expected %h", {rv, re, rd}, {2'b11, 32'h0}); end
        xfer(1'b1, 3'b011, 32'h0, 32'h22222222, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b11, 32'h0}) begin fails++; $display("FAIL ctrl_011_err: got %h expected %h", {rv, re, rd}, {2'b11, 32'h0}); end
        xfer(1'b0, 3'b110, 32'h10, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b11, 32'h0}) begin fails++; $display("FAIL ctrl_110_err: got %h expected %h", {rv, re, rd}, {2'b11, 32'h0}); end
        xfer(1'b1, 3'b100, 32'h0, 32'h00000033, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b11, 32'h0}) begin fails++; $display("FAIL store_bu_err: got %h expected %h", {rv, re, rd}, {2'b11, 32'h0}); end
        xfer(1'b0, 3'b010, 32'h0, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'h0}) begin fails++; $display("FAIL lw_000_unwritten: got %h expected %h", {rv, re, rd}, {2'b10, 32'h0}); end
    endtask

    task automatic test_misalign();
        xfer(1'b1, 3'b010, 32'h3FE, 32'h77777777, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b11, 32'h0}) begin fails++; $display("FAIL sw_3fe_err: got %h expected %h", {rv, re, rd}, {2'b11, 32'h0}); end
        xfer(1'b0, 3'b010, 32'h3FC, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'h0}) begin fails++; $display("FAIL lw_3fc_unwritten: got %h expected %h", {rv, re, rd}, {2'b10, 32'h0}); end
        xfer(1'b1, 3'b010, 32'h06, 32'hCAFEF00D, rv, re, rd);
`ifdef DMEM_MISALIGN_EN
        tests++; if ({rv, re, rd} !== {2'b10, 32'h0}) begin fails++; $display("FAIL sw_006_rsp: got %h expected %h", {rv, re, rd}, {2'b10, 32'h0}); end
        xfer(1'b0, 3'b010, 32'h04, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'hF00D0000}) begin fails++; $display("FAIL lw_004_mis: got %h expected %h", {rv, re, rd}, {2'b10, 32'hF00D0000}); end
        xfer(1'b0, 3'b010, 32'h08, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'h0000CAFE}) begin fails++; $display("FAIL lw_008_mis: got %h expected %h", {rv, re, rd}, {2'b10, 32'h0000CAFE}); end
        xfer(1'b0, 3'b001, 32'h07, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'hFFFFFEF0}) begin fails++; $display("FAIL lh_007_mis: got %h expected %h", {rv, re, rd}, {2'b10, 32'hFFFFFEF0}); end
`else
        tests++; if ({rv, re, rd} !== {2'b11, 32'h0}) begin fails++; $display("FAIL sw_006_err: got %h expected %h", {rv, re, rd}, {2'b11, 32'h0}); end
        xfer(1'b0, 3'b001, 32'h11, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b11, 32'h0}) begin fails++; $display("FAIL lh_011_err: got %h expected %h", {rv, re, rd}, {2'b11, 32'h0}); end
        xfer(1'b0, 3'b010, 32'h04, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'h0}) begin fails++; $display("FAIL lw_004_unwritten: got %h expected %h", {rv, re, rd}, {2'b10, 32'h0}); end
        xfer(1'b0, 3'b010, 32'h08, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'h0}) begin fails++; $display("FAIL lw_008_unwritten: got %h expected %h", {rv, re, rd}, {2'b10, 32'h0}); end
`endif
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        DMWr = 1'b0; DMCtrl = 3'b010; Address = 32'h10; ReqValid = 1'b1; RspReady = 1'b0;
        @(negedge clk);
        Address = 32'h20;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if ({RspValid, RspErr, DataRd, ReqReady} !== {2'b10, 32'h8899AABB, 1'b0}) begin
                fails++; $display("FAIL backpressure_hold_%0d: got %h expected %h", i, {RspValid, RspErr, DataRd, ReqReady}, {2'b10, 32'h8899AABB, 1'b0});
            end
            @(negedge clk);
        end
        RspReady = 1'b1; #1;
        tests++; if (ReqReady !== 1'b1) begin fails++; $display("FAIL backpressure_release_ready: got %b expected 1", ReqReady); end
        @(negedge clk);
        ReqValid = 1'b0;
        tests++; if ({RspValid, RspErr, DataRd} !== {2'b10, 32'h123455EF}) begin
            fails++; $display("FAIL backpressure_next_rsp: got %h expected %h", {RspValid, RspErr, DataRd}, {2'b10, 32'h123455EF});
        end
        @(negedge clk);
    endtask

    task automatic test_clear_request();
        int n = 0;
        Clear = 1'b1; ReqValid = 1'b1; DMWr = 1'b1; DMCtrl = 3'b010; Address = 32'h10; DataWr = 32'hFFFFFFFF; RspReady = 1'b1;
        #1;
        tests++; if (ReqReady !== 1'b0) begin fails++; $display("FAIL clear_blocks_ready: got %b expected 0", ReqReady); end
        @(negedge clk);
        Clear = 1'b0; ReqValid = 1'b0; #1;
        tests++; if ({Busy, RspValid} !== 2'b10) begin fails++; $display("FAIL clear_busy_no_accept: got %b expected 10", {Busy, RspValid}); end
        while (Busy === 1'b1 && n < 400) begin
            n++;
            @(negedge clk); #1;
        end
        tests++; if (n != 256) begin fails++; $display("FAIL clear_cycles: got %0d expected 256", n); end
        @(negedge clk);
        xfer(1'b0, 3'b010, 32'h10, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'h0}) begin fails++; $display("FAIL lw_010_after_clear: got %h expected %h", {rv, re, rd}, {2'b10, 32'h0}); end
        xfer(1'b0, 3'b010, 32'h20, 32'h0, rv, re, rd);
        tests++; if ({rv, re, rd} !== {2'b10, 32'h0}) begin fails++; $display("FAIL lw_020_after_clear: got %h expected %h", {rv, re, rd}, {2'b10, 32'h0}); end
    endtask

    initial begin
        test_reset();
        test_clear_result();
        test_store_load();
        test_partial();
        test_errors();
        test_misalign();
        test_backpressure();
        test_clear_request();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
